// File: rtl/branch_cond_unit_if.sv
// Bundle for the branch condition unit: flag update, branch request handshake and resolution pulse.
// Optional BRANCH_STATS_EN adds the statistics counters to the bundle.
interface branch_cond_unit_if #(
  parameter int PC_W   = 16,
  parameter int DISP_W = 8
);
  logic        [3:0]        code_in;
  logic                     flag_we;
  logic                     br_valid;
  logic                     br_ready;
  logic        [3:0]        br_cond;
  logic        [PC_W-1:0]   br_pc;
  logic signed [DISP_W-1:0] br_disp;
  logic        [3:0]        flags;
  logic                     res_valid;
  logic                     res_taken;
  logic                     redirect;
  logic        [PC_W-1:0]   res_target;
  logic                     illegal;
`ifdef BRANCH_STATS_EN
  logic        [15:0]       stat_branches;
  logic        [15:0]       stat_taken;
`endif

  modport master (
    output code_in, flag_we, br_valid, br_cond, br_pc, br_disp,
    input  br_ready, flags, res_valid, res_taken, redirect, res_target, illegal
`ifdef BRANCH_STATS_EN
    , input stat_branches, stat_taken
`endif
  );

  modport slave (
    input  code_in, flag_we, br_valid, br_cond, br_pc, br_disp,
    output br_ready, flags, res_valid, res_taken, redirect, res_target, illegal
`ifdef BRANCH_STATS_EN
    , output stat_branches, stat_taken
`endif
  );
endinterface

// File: rtl/branch_cond_unit.sv
// Branch condition unit: architectural {S,Z,C,V} flag register plus a two-cycle branch resolver.
// Optional feature macro: BRANCH_STATS_EN (saturating branch/taken counters).
module branch_cond_unit #(
  parameter int PC_W   = 16,
  parameter int DISP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  branch_cond_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  // Returns {taken, illegal}; flags are packed {S,Z,C,V}.
  function automatic logic [1:0] decode_cond(input logic [3:0] cond, input logic [3:0] f);
    logic s, z, c, v;
    logic taken;
    logic ill;
    s     = f[3];
    z     = f[2];
    c     = f[1];
    v     = f[0];
    taken = 1'b0;
    ill   = 1'b0;
    case (cond)
      4'b0000: taken = z;
      4'b0001: taken = s ^ v;
      4'b0010: taken = z | (s ^ v);
      4'b0011: taken = ~z;
      4'b0100: taken = c;
      4'b0101: taken = ~c;
      4'b0110: taken = v;
      4'b0111: taken = 1'b1;
      default: ill   = 1'b1;
    endcase
    return {taken, ill};
  endfunction

  function automatic logic [PC_W-1:0] calc_target(input logic [PC_W-1:0] pc,
                                                  input logic signed [DISP_W-1:0] disp);
    logic signed [PC_W-1:0] sx;
    sx = {{(PC_W-DISP_W){disp[DISP_W-1]}}, disp};
    return pc + PC_W'(1) + PC_W'(sx);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     w_accept;
  logic                     w_resp;
  logic        [3:0]        r_flags;
  logic        [3:0]        w_flags_eff;

  logic        [3:0]        r_cond_p0;
  logic        [PC_W-1:0]   r_pc_p0;
  logic signed [DISP_W-1:0] r_disp_p0;
  logic        [3:0]        r_flags_p0;

  logic        [1:0]        w_dec_p0;
  logic        [PC_W-1:0]   w_target_p0;
  logic                     r_taken_p1;
  logic                     r_illegal_p1;
  logic        [PC_W-1:0]   r_target_p1;

  // Same-cycle flag write is forwarded into the branch snapshot.
  assign w_flags_eff = bus.flag_we ? bus.code_in : r_flags;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags <= 4'b0000;
    end else if (bus.flag_we) begin
      r_flags <= bus.code_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.br_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = EVAL;
        end
      end
      EVAL:    w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Stage p0: request capture with flag snapshot
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_cond_p0  <= bus.br_cond;
      r_pc_p0    <= bus.br_pc;
      r_disp_p0  <= bus.br_disp;
      r_flags_p0 <= w_flags_eff;
    end
  end

  assign w_dec_p0    = decode_cond(r_cond_p0, r_flags_p0);
  assign w_target_p0 = calc_target(r_pc_p0, r_disp_p0);

  // Stage p1: resolved decision and target, presented during RESP
  always_ff @(posedge clk) begin
    if (r_state == EVAL) begin
      r_taken_p1   <= w_dec_p0[1];
      r_illegal_p1 <= w_dec_p0[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_target_p1 <= '0;
    end else if (r_state == EVAL) begin
      r_target_p1 <= w_target_p0;
    end
  end

  // Reset during RESP suppresses the pulse in that same cycle.
  assign w_resp = (r_state == RESP) && !rst;

  assign bus.br_ready   = (r_state == IDLE);
  assign bus.flags      = r_flags;
  assign bus.res_valid  = w_resp;
  assign bus.res_taken  = w_resp & r_taken_p1;
  assign bus.redirect   = w_resp & r_taken_p1;
  assign bus.illegal    = w_resp & r_illegal_p1;
  assign bus.res_target = r_target_p1;

`ifdef BRANCH_STATS_EN
  logic [15:0] r_stat_branches;
  logic [15:0] r_stat_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_branches <= 16'd0;
      r_stat_taken    <= 16'd0;
    end else if (w_resp) begin
      r_stat_branches <= sat_inc(r_stat_branches);
      if (r_taken_p1) begin
        r_stat_taken <= sat_inc(r_stat_taken);
      end
    end
  end

  assign bus.stat_branches = r_stat_branches;
  assign bus.stat_taken    = r_stat_taken;
`endif

endmodule

// File: tb/tb_branch_cond_unit.sv
// Directed bench for branch_cond_unit: expectations queued at issue, checked by a separate monitor.
module tb_branch_cond_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_cond_unit_if #(.PC_W(16), .DISP_W(8)) bus ();

  branch_cond_unit #(.PC_W(16), .DISP_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic        taken;
    logic        ill;
    logic [15:0] target;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   total  = 0;
  int   passed = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic t, input logic il, input logic [15:0] tg);
    exp_t e;
    e.taken  = t;
    e.ill    = il;
    e.target = tg;
    e.due    = cyc + 2;
    sb.push_back(e);
  endtask

  task automatic set_flags(input logic [3:0] code);
    bus.flag_we = 1'b1;
    bus.code_in = code;
    tick();
    bus.flag_we = 1'b0;
    chk("flags_write", {28'd0, bus.flags}, {28'd0, code});
  endtask

  task automatic send(input logic [3:0] cond, input logic [15:0] pc, input logic [7:0] disp,
                      input logic t, input logic il, input logic [15:0] tg,
                      input logic fwe = 1'b0, input logic [3:0] fcode = 4'd0,
                      input logic ewe = 1'b0, input logic [3:0] ecode = 4'd0);
    int n;
    n = 0;
    while (!bus.br_ready && n < 10) begin
      tick();
      n++;
    end
    if (!bus.br_ready) begin
      total++;
      $display("FAIL ready_timeout: br_ready=%0b expected 1", bus.br_ready);
      return;
    end
    bus.br_valid = 1'b1;
    bus.br_cond  = cond;
    bus.br_pc    = pc;
    bus.br_disp  = disp;
    bus.flag_we  = fwe;
    bus.code_in  = fcode;
    push(t, il, tg);
    tick();
    bus.br_valid = 1'b0;
    bus.flag_we  = ewe;
    bus.code_in  = ecode;
    chk("ready_eval", {31'd0, bus.br_ready}, 32'd0);
    tick();
    bus.flag_we = 1'b0;
    chk("ready_resp", {31'd0, bus.br_ready}, 32'd0);
    tick();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (bus.res_valid) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_res: res_valid=1 expected 0 at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          chk("res_taken",  {31'd0, bus.res_taken}, {31'd0, e.taken});
          chk("redirect",   {31'd0, bus.redirect},  {31'd0, e.taken});
          chk("illegal",    {31'd0, bus.illegal},   {31'd0, e.ill});
          chk("res_target", {16'd0, bus.res_target}, {16'd0, e.target});
          chk("latency",    cyc, e.due);
        end
      end else begin
        chk("quiet_outputs", {29'd0, bus.res_taken, bus.redirect, bus.illegal}, 32'd0);
      end
    end
  end

  initial begin
    rst          = 1'b1;
    bus.code_in  = 4'd0;
    bus.flag_we  = 1'b0;
    bus.br_valid = 1'b0;
    bus.br_cond  = 4'd0;
    bus.br_pc    = 16'd0;
    bus.br_disp  = 8'd0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_flags",  {28'd0, bus.flags}, 32'd0);
    chk("rst_ready",  {31'd0, bus.br_ready}, 32'd1);
    chk("rst_valid",  {31'd0, bus.res_valid}, 32'd0);
    chk("rst_target", {16'd0, bus.res_target}, 32'd0);
    mon_en = 1'b1;

    // Basic BE taken
    set_flags(4'b0100);
    send(4'b0000, 16'h0010, 8'h05, 1'b1, 1'b0, 16'h0016);

    // S=1, V=0
    set_flags(4'b1000);
    send(4'b0001, 16'h0020, 8'h10, 1'b1, 1'b0, 16'h0031);
    send(4'b0010, 16'h0040, 8'hF0, 1'b1, 1'b0, 16'h0031);
    send(4'b0011, 16'h1000, 8'h00, 1'b1, 1'b0, 16'h1001);
    send(4'b0000, 16'h0100, 8'hFE, 1'b0, 1'b0, 16'h00FF);

    // C=1
    set_flags(4'b0010);
    send(4'b0100, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h0001);
    send(4'b0101, 16'h0010, 8'h01, 1'b0, 1'b0, 16'h0012);
    send(4'b0110, 16'h0020, 8'h00, 1'b0, 1'b0, 16'h0021);
    send(4'b0111, 16'h0030, 8'h02, 1'b1, 1'b0, 16'h0033);

    // V=1
    set_flags(4'b0001);
    send(4'b0110, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h0001);
    send(4'b0001, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h0001);
    send(4'b0010, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h0001);

    // Forwarding at accept, later write during EVAL ignored
    set_flags(4'b0000);
    send(4'b0000, 16'h0200, 8'h01, 1'b1, 1'b0, 16'h0202, 1'b1, 4'b0100, 1'b1, 4'b0000);
    chk("flags_after_eval_write", {28'd0, bus.flags}, 32'd0);

    // Target wrap
    send(4'b0111, 16'hFFFE, 8'h03, 1'b1, 1'b0, 16'h0002);
    send(4'b0101, 16'h0000, 8'h80, 1'b1, 1'b0, 16'hFF81);

    // Undefined condition
    send(4'b1010, 16'h0300, 8'h02, 1'b0, 1'b1, 16'h0303);

    // br_valid held high: second request only taken back in IDLE
    bus.br_valid = 1'b1;
    bus.br_cond  = 4'b0111;
    bus.br_pc    = 16'h0010;
    bus.br_disp  = 8'h00;
    push(1'b1, 1'b0, 16'h0011);
    tick();
    chk("held_ready_eval", {31'd0, bus.br_ready}, 32'd0);
    tick();
    chk("held_ready_resp", {31'd0, bus.br_ready}, 32'd0);
    tick();
    chk("held_ready_idle", {31'd0, bus.br_ready}, 32'd1);
    push(1'b1, 1'b0, 16'h0011);
    tick();
    bus.br_valid = 1'b0;
    tick();
    tick();
    chk("held_back_idle", {31'd0, bus.br_ready}, 32'd1);

    // Reset while in EVAL, with a simultaneous flag write
    set_flags(4'b0110);
    bus.br_valid = 1'b1;
    bus.br_cond  = 4'b0111;
    bus.br_pc    = 16'h0050;
    bus.br_disp  = 8'h00;
    tick();
    bus.br_valid = 1'b0;
    rst          = 1'b1;
    bus.flag_we  = 1'b1;
    bus.code_in  = 4'hF;
    tick();
    rst         = 1'b0;
    bus.flag_we = 1'b0;
    chk("abort_flags",  {28'd0, bus.flags}, 32'd0);
    chk("abort_ready",  {31'd0, bus.br_ready}, 32'd1);
    chk("abort_valid",  {31'd0, bus.res_valid}, 32'd0);
    chk("abort_target", {16'd0, bus.res_target}, 32'd0);
    tick();
    tick();
    tick();

`ifdef BRANCH_STATS_EN
    chk("stat_branches_rst", {16'd0, bus.stat_branches}, 32'd0);
    send(4'b0111, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h0001);
    send(4'b0000, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0001);
    send(4'b0011, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h0001);
    chk("stat_branches", {16'd0, bus.stat_branches}, 32'd3);
    chk("stat_taken",    {16'd0, bus.stat_taken},    32'd2);
`endif

    tick();
    tick();
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
